// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared constants and state encoding for the data RAM arbiter
package dmem_arbiter_pkg;

  localparam int DMEM_ADDR_W    = 12;
  localparam int DMEM_DATA_W    = 32;
  localparam int DMEM_MAX_BURST = 16;
  localparam int DMEM_LEN_W     = 5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

endpackage

// File: rtl/dmem_arbiter_ret_pipe.sv
// rtl/dmem_arbiter_ret_pipe.sv - one-stage pending flag and index for VGA read returns
module dmem_arbiter_ret_pipe
  import dmem_arbiter_pkg::*;
#(
  parameter int LEN_W = DMEM_LEN_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue_i,
  input  logic [LEN_W-1:0] idx_i,
  output logic             pend_o,
  output logic [LEN_W-1:0] idx_o
);

  logic             pend_q;
  logic [LEN_W-1:0] idx_q;

  // Remember which burst word the RAM returns next cycle; CPU cycles leave the flag clear
  always_ff @(posedge clock) begin
    if (!reset) begin
      pend_q <= 1'b0;
      idx_q  <= '0;
    end else begin
      pend_q <= issue_i;
      if (issue_i) begin
        idx_q <= idx_i;
      end
    end
  end

  assign pend_o = pend_q;
  assign idx_o  = idx_q;

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU-priority sharing of the data RAM port with a VGA burst reader
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W,
  parameter int LEN_W  = DMEM_LEN_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wren,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic [DATA_W-1:0] cpu_q,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_base,
  input  logic [LEN_W-1:0]  vga_len,
  output logic              vga_busy,
  output logic              vga_rvalid,
  output logic [LEN_W-1:0]  vga_rindex,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_done,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  state_t            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx_q;

  logic              issue;
  logic              accept;
  logic              last_issue;
  logic [ADDR_W-1:0] vga_addr;
  logic              pend;
  logic [LEN_W-1:0]  pend_idx;

  // The CPU has no stall, so VGA only gets cycles where cpu_req is low
  assign issue      = (state_q == ST_BURST) && !cpu_req;
  assign last_issue = (idx_q == len_q - 1'b1);
  assign vga_addr   = base_q + ADDR_W'(idx_q);
  assign vga_busy   = (state_q != ST_IDLE) | pend;
  assign accept     = (state_q == ST_IDLE) && vga_req && !vga_busy && (vga_len != '0);

  // Burst sequencer: capture the request, then issue one word per free cycle until len words go out
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            base_q  <= vga_base;
            len_q   <= vga_len;
            idx_q   <= '0;
            state_q <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (issue) begin
            idx_q <= idx_q + 1'b1;
            if (last_issue) begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Port mux: CPU owns the port whenever it asks; writes are blocked while reset is held
  always_comb begin
    ram_addr = cpu_addr;
    ram_din  = cpu_data;
    ram_wen  = 1'b0;
    if (cpu_req) begin
      ram_wen = cpu_wren;
    end else if (issue) begin
      ram_addr = vga_addr;
    end
    if (!reset) begin
      ram_wen = 1'b0;
    end
  end

  dmem_arbiter_ret_pipe #(
    .LEN_W (LEN_W)
  ) u_ret_pipe (
    .clock   (clock),
    .reset   (reset),
    .issue_i (issue),
    .idx_i   (idx_q),
    .pend_o  (pend),
    .idx_o   (pend_idx)
  );

  // RAM data is only tagged as VGA data in the cycle after a VGA issue
  assign cpu_q      = ram_dout;
  assign vga_rvalid = pend;
  assign vga_rindex = pend ? pend_idx : '0;
  assign vga_rdata  = pend ? ram_dout : '0;
  assign vga_done   = pend && (pend_idx == len_q - 1'b1);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for the data RAM arbiter
module tb_dmem_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int LW = 5;

  logic          clock = 1'b0;
  logic          reset;
  logic          cpu_req;
  logic          cpu_wren;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_data;
  logic [DW-1:0] cpu_q;
  logic          vga_req;
  logic [AW-1:0] vga_base;
  logic [LW-1:0] vga_len;
  logic          vga_busy;
  logic          vga_rvalid;
  logic [LW-1:0] vga_rindex;
  logic [DW-1:0] vga_rdata;
  logic          vga_done;
  logic          ram_wen;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [LW-1:0] idx;
    logic [DW-1:0] data;
    logic          done;
  } exp_t;

  exp_t sb[$];

  always #5 clock = ~clock;

  dmem_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_wren   (cpu_wren),
    .cpu_addr   (cpu_addr),
    .cpu_data   (cpu_data),
    .cpu_q      (cpu_q),
    .vga_req    (vga_req),
    .vga_base   (vga_base),
    .vga_len    (vga_len),
    .vga_busy   (vga_busy),
    .vga_rvalid (vga_rvalid),
    .vga_rindex (vga_rindex),
    .vga_rdata  (vga_rdata),
    .vga_done   (vga_done),
    .ram_wen    (ram_wen),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout)
  );

  // Single-port RAM with registered read
  always @(posedge clock) begin
    if (ram_wen) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return 32'hC0DE0000 | {20'h0, a};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_burst(input logic [AW-1:0] base, input int len, input int upto);
    exp_t e;
    logic [AW-1:0] a;
    for (int i = 0; i < upto; i++) begin
      a = base + AW'(i);
      e.idx = LW'(i);
      e.data = pat(a);
      e.done = (i == len - 1);
      sb.push_back(e);
    end
  endtask

  // Wait from the current negedge for done; cyc is the burst cycle number of that negedge
  task automatic wait_done(input int start_cyc, input int exp_cyc, input string nm);
    int cyc;
    bit found;
    cyc = start_cyc;
    found = 0;
    for (int k = 0; k < 100; k++) begin
      if (vga_done === 1'b1) begin
        found = 1;
        break;
      end
      @(negedge clock);
      cyc++;
    end
    if (!found) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no done required done by cycle %0d", nm, exp_cyc);
    end else begin
      chk(nm, 32'(cyc), 32'(exp_cyc));
      @(negedge clock);
      chk({nm, "_busy_drop"}, {31'h0, vga_busy}, 32'h0);
    end
  endtask

  task automatic run_burst(input logic [AW-1:0] base, input int len, input bit check_addr);
    logic [AW-1:0] ea;
    push_burst(base, len, len);
    tick();
    vga_base = base;
    vga_len  = LW'(len);
    vga_req  = 1'b1;
    tick();
    vga_req = 1'b0;
    @(negedge clock);
    chk("busy_after_accept", {31'h0, vga_busy}, 32'h1);
    if (check_addr) begin
      for (int c = 0; c < len; c++) begin
        ea = base + AW'(c);
        chk("wrap_addr", {20'h0, ram_addr}, {20'h0, ea});
        if (c < len - 1) @(negedge clock);
      end
      wait_done(len - 1, len, "done_latency");
    end else begin
      wait_done(0, len, "done_latency");
    end
  endtask

  // Monitor: every VGA return must match the head of the scoreboard
  always @(negedge clock) begin : monitor
    exp_t e;
    if (vga_rvalid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rvalid: got rvalid index %0d required no rvalid", vga_rindex);
      end else begin
        e = sb.pop_front();
        chk("rindex", {27'h0, vga_rindex}, {27'h0, e.idx});
        chk("rdata", vga_rdata, e.data);
        chk("done_flag", {31'h0, vga_done}, {31'h0, e.done});
      end
    end else if (vga_done !== 1'b0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL stray_done: got done %b without rvalid required 0", vga_done);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    for (int i = 0; i < (1 << AW); i++) mem[i] = pat(AW'(i));

    reset    = 1'b0;
    vga_req  = 1'b1;
    vga_base = 12'h010;
    vga_len  = 5'd4;
    cpu_req  = 1'b1;
    cpu_wren = 1'b1;
    cpu_addr = 12'h123;
    cpu_data = 32'h55;

    // Reset held for 3 cycles with requests pending
    repeat (3) begin
      @(negedge clock);
      chk("rst_busy",   {31'h0, vga_busy},   32'h0);
      chk("rst_rvalid", {31'h0, vga_rvalid}, 32'h0);
      chk("rst_done",   {31'h0, vga_done},   32'h0);
      chk("rst_rindex", {27'h0, vga_rindex}, 32'h0);
      chk("rst_rdata",  vga_rdata,           32'h0);
      chk("rst_wen",    {31'h0, ram_wen},    32'h0);
    end
    tick();
    reset    = 1'b1;
    vga_req  = 1'b0;
    cpu_req  = 1'b0;
    cpu_wren = 1'b0;

    // Idle burst
    run_burst(12'h010, 4, 1'b0);

    // Preemption in the 2nd and 3rd burst cycles
    push_burst(12'h050, 4, 4);
    tick();
    vga_base = 12'h050;
    vga_len  = 5'd4;
    vga_req  = 1'b1;
    tick();
    vga_req = 1'b0;
    @(negedge clock);
    chk("pre_vga_addr0", {20'h0, ram_addr}, 32'h050);
    tick();
    cpu_req  = 1'b1;
    cpu_addr = 12'h030;
    @(negedge clock);
    chk("pre_cpu_addr1", {20'h0, ram_addr}, 32'h030);
    tick();
    cpu_addr = 12'h031;
    @(negedge clock);
    chk("pre_cpu_addr2", {20'h0, ram_addr}, 32'h031);
    chk("pre_cpu_q1", cpu_q, pat(12'h030));
    tick();
    cpu_req = 1'b0;
    @(negedge clock);
    chk("pre_cpu_q2", cpu_q, pat(12'h031));
    chk("pre_vga_addr1", {20'h0, ram_addr}, 32'h051);
    wait_done(3, 6, "preempt_done");

    // CPU store then load during a burst
    push_burst(12'h060, 4, 4);
    tick();
    vga_base = 12'h060;
    vga_len  = 5'd4;
    vga_req  = 1'b1;
    tick();
    vga_req = 1'b0;
    tick();
    cpu_req  = 1'b1;
    cpu_wren = 1'b1;
    cpu_addr = 12'h020;
    cpu_data = 32'hDEADBEEF;
    @(negedge clock);
    chk("st_wen",  {31'h0, ram_wen},    32'h1);
    chk("st_addr", {20'h0, ram_addr},   32'h020);
    chk("st_din",  ram_din,             32'hDEADBEEF);
    tick();
    cpu_wren = 1'b0;
    @(negedge clock);
    chk("ld_wen", {31'h0, ram_wen}, 32'h0);
    tick();
    cpu_req = 1'b0;
    @(negedge clock);
    chk("ld_cpu_q", cpu_q, 32'hDEADBEEF);
    wait_done(3, 6, "store_done");

    // Address wrap
    run_burst(12'hFFE, 4, 1'b1);

    // Zero length is ignored
    tick();
    vga_base = 12'h070;
    vga_len  = 5'd0;
    vga_req  = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("zero_len_busy", {31'h0, vga_busy}, 32'h0);
    end
    tick();
    vga_req = 1'b0;
    @(negedge clock);
    chk("zero_len_busy_after", {31'h0, vga_busy}, 32'h0);

    // Reset while idx 2 of an 8-word burst is outstanding
    push_burst(12'h100, 8, 2);
    tick();
    vga_base = 12'h100;
    vga_len  = 5'd8;
    vga_req  = 1'b1;
    tick();
    vga_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    repeat (4) begin
      @(negedge clock);
      chk("abort_busy", {31'h0, vga_busy}, 32'h0);
    end
    run_burst(12'h200, 1, 1'b0);

    repeat (3) tick();
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
